// File: rtl/state_pkg.sv
// Shared game-state types consumed by the player controllers.
// move_t is the per-frame movement command produced by the GPIO player link.
package state_pkg;

    typedef enum logic [1:0] {
        MOVE_NONE  = 2'b00,
        MOVE_LEFT  = 2'b01,
        MOVE_RIGHT = 2'b10
    } move_t;

    // Both directions requested at once cancel out rather than favouring a side.
    function automatic move_t decode_move(input logic left, input logic right);
        case ({left, right})
            2'b10:   return MOVE_LEFT;
            2'b01:   return MOVE_RIGHT;
            default: return MOVE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Two-flop synchroniser and qualify-then-commit glitch filter for one raw GPIO line.
// level/rise/fall change together, FILTER_CYCLES cycles after the synchronised line settles.
module gpio_debounce #(
    parameter int unsigned FILTER_CYCLES = 650,
    parameter int unsigned CNT_W         = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        LOW,
        QUAL_HIGH,
        HIGH,
        QUAL_LOW
    } filt_state_t;

    // The cycle that enters a QUAL state is already the first stable cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((FILTER_CYCLES > 1) ? FILTER_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam bit               SINGLE   = (FILTER_CYCLES == 1);

    logic             sync_p0;
    logic             sync_p1;
    filt_state_t      state_q;
    filt_state_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise_d;
    logic             fall_d;

    // Stage p0/p1: metastability guard for the asynchronous pin
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
        end
    end

    // Filter FSM on the synchronised line
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            LOW: begin
                if (sync_p1) begin
                    if (SINGLE) begin
                        state_d = HIGH;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = QUAL_HIGH;
                        cnt_d   = '0;
                    end
                end
            end
            QUAL_HIGH: begin
                if (!sync_p1) begin
                    state_d = LOW;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = HIGH;
                    rise_d  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!sync_p1) begin
                    if (SINGLE) begin
                        state_d = LOW;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = QUAL_LOW;
                        cnt_d   = '0;
                    end
                end
            end
            QUAL_LOW: begin
                if (sync_p1) begin
                    state_d = HIGH;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = LOW;
                    fall_d  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOW;
            cnt_q   <= '0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    assign level = (state_q == HIGH) || (state_q == QUAL_LOW);

endmodule

// File: rtl/gpio_rx_ctl.sv
// Receiver for the inter-board GPIO player link: filters left/right lines and
// latches one movement command per video frame on the vsync rising edge.
module gpio_rx_ctl
    import state_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 650,
    parameter int unsigned CNT_W         = 10
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  gpio_left,
    input  logic  gpio_right,
    input  logic  v_tick,
    output logic  left_lvl,
    output logic  right_lvl,
    output logic  left_press,
    output logic  right_press,
    output logic  left_release,
    output logic  right_release,
    output move_t move,
    output logic  frame_strobe
);

    logic v_tick_p0;
    logic v_rise_p1;
    logic sticky_l;
    logic sticky_r;
    logic take_l;
    logic take_r;

    gpio_debounce #(
        .FILTER_CYCLES(FILTER_CYCLES),
        .CNT_W        (CNT_W)
    ) u_left (
        .clk  (clk),
        .rst  (rst),
        .din  (gpio_left),
        .level(left_lvl),
        .rise (left_press),
        .fall (left_release)
    );

    gpio_debounce #(
        .FILTER_CYCLES(FILTER_CYCLES),
        .CNT_W        (CNT_W)
    ) u_right (
        .clk  (clk),
        .rst  (rst),
        .din  (gpio_right),
        .level(right_lvl),
        .rise (right_press),
        .fall (right_release)
    );

    // Stage p0/p1: vsync history and registered rising-edge flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_tick_p0 <= 1'b0;
            v_rise_p1 <= 1'b0;
        end else begin
            v_tick_p0 <= v_tick;
            v_rise_p1 <= v_tick & ~v_tick_p0;
        end
    end

    assign take_l = sticky_l | left_lvl | left_press;
    assign take_r = sticky_r | right_lvl | right_press;

    // Stage p2: frame sample; sticky reloads with the live level so a held key spans frames
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_l     <= 1'b0;
            sticky_r     <= 1'b0;
            move         <= MOVE_NONE;
            frame_strobe <= 1'b0;
        end else if (v_rise_p1) begin
            sticky_l     <= left_lvl;
            sticky_r     <= right_lvl;
            move         <= decode_move(take_l, take_r);
            frame_strobe <= 1'b1;
        end else begin
            sticky_l     <= take_l;
            sticky_r     <= take_r;
            frame_strobe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gpio_rx_ctl.sv
// Self-checking bench for gpio_rx_ctl with FILTER_CYCLES = 4: directed tables,
// hand-written corner sequences and a randomized run against a per-cycle reference model.
module tb_gpio_rx_ctl;
    import state_pkg::*;

    localparam int FC   = 4;
    localparam int MAXC = 4000;

    typedef struct {
        int len;
        int npress;
        int poff;
        int roff;
    } glitch_t;

    typedef struct {
        bit    l;
        bit    r;
        move_t mv;
    } dec_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  gpio_left = 1'b0;
    logic  gpio_right = 1'b0;
    logic  v_tick = 1'b0;
    logic  left_lvl, right_lvl, left_press, right_press, left_release, right_release;
    move_t move;
    logic  frame_strobe;

    int checks = 0;
    int errors = 0;

    bit    pin_l[MAXC];
    bit    pin_r[MAXC];
    bit    vt_h[MAXC];
    bit    lv_l[MAXC];
    bit    lv_r[MAXC];
    int    cyc = 0;
    int    base = 0;
    int    last_s = -1;
    move_t exp_move = MOVE_NONE;
    int    npress_l = 0;

    always #5 clk = ~clk;

    gpio_rx_ctl #(
        .FILTER_CYCLES(FC),
        .CNT_W        (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .gpio_left    (gpio_left),
        .gpio_right   (gpio_right),
        .v_tick       (v_tick),
        .left_lvl     (left_lvl),
        .right_lvl    (right_lvl),
        .left_press   (left_press),
        .right_press  (right_press),
        .left_release (left_release),
        .right_release(right_release),
        .move         (move),
        .frame_strobe (frame_strobe)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit pin_at(input int ch, input int k);
        if (k < base) return 1'b0;
        return (ch != 0) ? pin_r[k] : pin_l[k];
    endfunction

    function automatic bit lvl_at(input int ch, input int k);
        if (k < base) return 1'b0;
        return (ch != 0) ? lv_r[k] : lv_l[k];
    endfunction

    function automatic bit vt_at(input int k);
        if (k < base) return 1'b0;
        return vt_h[k];
    endfunction

    // The synchronised line in cycle k is the pin of cycle k-2; the level flips once
    // the last FC synchronised samples all disagree with it.
    function automatic bit next_level(input int ch, input int c);
        bit prev;
        bit flip;
        prev = lvl_at(ch, c - 1);
        flip = 1'b1;
        for (int k = 1; k <= FC; k++)
            if (pin_at(ch, c - k - 2) == prev) flip = 1'b0;
        return flip ? !prev : prev;
    endfunction

    task automatic model_eval(output logic [8:0] ev);
        bit nl, nr, pl, pr, sl, sr, stb;
        int c;
        int st;
        c   = cyc;
        stb = 1'b0;
        pl  = lvl_at(0, c - 1);
        pr  = lvl_at(1, c - 1);
        nl  = next_level(0, c);
        nr  = next_level(1, c);
        lv_l[c] = nl;
        lv_r[c] = nr;
        // a vsync rise seen in cycle s-1 makes cycle s the sample; result shows in s+1
        if ((c - 1 > base) && vt_at(c - 2) && !vt_at(c - 3)) begin
            st = (last_s >= 0) ? last_s : base;
            sl = 1'b0;
            sr = 1'b0;
            for (int k = st; k <= c - 1; k++) begin
                sl = sl | lvl_at(0, k);
                sr = sr | lvl_at(1, k);
            end
            if (sl && !sr)      exp_move = MOVE_LEFT;
            else if (sr && !sl) exp_move = MOVE_RIGHT;
            else                exp_move = MOVE_NONE;
            stb    = 1'b1;
            last_s = c - 1;
        end
        ev = {nl, nr, nl & !pl, nr & !pr, !nl & pl, !nr & pr, stb, exp_move};
    endtask

    task automatic step();
        logic [8:0] ev;
        logic [8:0] av;
        if (cyc >= MAXC - 2) begin
            $display("FAIL cycle_budget: got %0d, expected below %0d", cyc, MAXC - 2);
            $fatal(1);
        end
        pin_l[cyc] = gpio_left;
        pin_r[cyc] = gpio_right;
        vt_h[cyc]  = v_tick;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) begin
            ev = '0;
            lv_l[cyc] = 1'b0;
            lv_r[cyc] = 1'b0;
        end else begin
            model_eval(ev);
        end
        av = {left_lvl, right_lvl, left_press, right_press, left_release, right_release,
              frame_strobe, move};
        cmp("outputs", 32'(av), 32'(ev));
        if (left_press) npress_l++;
    endtask

    task automatic release_reset();
        rst       = 1'b1;
        base      = cyc;
        lv_l[cyc] = 1'b0;
        lv_r[cyc] = 1'b0;
        last_s    = -1;
        exp_move  = MOVE_NONE;
    endtask

    task automatic async_reset(input int n);
        rst = 1'b0;
        #1;
        cmp("async_reset_outputs",
            32'({left_lvl, right_lvl, left_press, right_press, left_release, right_release,
                 frame_strobe, move}), 32'd0);
        repeat (n) step();
        release_reset();
    endtask

    task automatic frame(input int hi, output int off, output int nstb, output move_t m);
        off  = -1;
        nstb = 0;
        m    = MOVE_NONE;
        v_tick = 1'b1;
        for (int t = 1; t <= hi + 4; t++) begin
            if (t > hi) v_tick = 1'b0;
            step();
            if (frame_strobe) begin
                nstb++;
                if (off < 0) begin
                    off = t;
                    m   = move;
                end
            end
        end
    endtask

    initial begin
        glitch_t gt[4];
        dec_t    dt[4];
        int      off, roff, nstb, np, n0, hl, hr, vcnt, vper, vhi;
        move_t   m;

        gt[0] = '{len: 1,  npress: 0, poff: -1, roff: -1};
        gt[1] = '{len: 3,  npress: 0, poff: -1, roff: -1};
        gt[2] = '{len: 4,  npress: 1, poff: 6,  roff: 10};
        gt[3] = '{len: 10, npress: 1, poff: 6,  roff: 16};
        dt[0] = '{l: 1'b1, r: 1'b0, mv: MOVE_LEFT};
        dt[1] = '{l: 1'b0, r: 1'b1, mv: MOVE_RIGHT};
        dt[2] = '{l: 1'b1, r: 1'b1, mv: MOVE_NONE};
        dt[3] = '{l: 1'b0, r: 1'b0, mv: MOVE_NONE};

        // reset held with pins and vsync toggling
        for (int i = 0; i < 8; i++) begin
            gpio_left  = i[0];
            gpio_right = !i[0];
            v_tick     = i[1];
            step();
        end
        cmp("reset_move", 32'(move), 32'(MOVE_NONE));
        gpio_left  = 1'b0;
        gpio_right = 1'b0;
        v_tick     = 1'b0;
        release_reset();
        nstb = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (frame_strobe) nstb++;
        end
        cmp("no_strobe_after_reset", 32'(nstb), 32'd0);

        // glitch rejection / acceptance table on the left line
        for (int g = 0; g < 4; g++) begin
            np   = 0;
            off  = -1;
            roff = -1;
            gpio_left = 1'b1;
            for (int t = 1; t <= gt[g].len + 10; t++) begin
                if (t > gt[g].len) gpio_left = 1'b0;
                step();
                if (left_press) begin
                    np++;
                    if (off < 0) off = t;
                end
                if (left_release && roff < 0) roff = t;
            end
            cmp("glitch_press_count", 32'(np), 32'(gt[g].npress));
            cmp("glitch_press_offset", 32'(off), 32'(gt[g].poff));
            cmp("glitch_release_offset", 32'(roff), 32'(gt[g].roff));
            repeat (4) step();
        end

        // decode table: levels held across one edge, then a flush frame
        frame(4, off, nstb, m);
        for (int i = 0; i < 4; i++) begin
            gpio_left  = dt[i].l;
            gpio_right = dt[i].r;
            repeat (8) step();
            frame(4, off, nstb, m);
            cmp("decode_move", 32'(m), 32'(dt[i].mv));
            cmp("decode_latency", 32'(off), 32'd2);
            gpio_left  = 1'b0;
            gpio_right = 1'b0;
            repeat (8) step();
            frame(4, off, nstb, m);
        end

        // short right tap entirely between two edges
        gpio_right = 1'b1;
        repeat (8) step();
        gpio_right = 1'b0;
        repeat (10) step();
        frame(4, off, nstb, m);
        cmp("tap_move", 32'(m), 32'(MOVE_RIGHT));
        cmp("tap_latency", 32'(off), 32'd2);
        frame(4, off, nstb, m);
        cmp("tap_next_frame", 32'(m), 32'(MOVE_NONE));

        // left held across three edges, long vsync pulses
        n0 = npress_l;
        gpio_left = 1'b1;
        repeat (8) step();
        for (int i = 0; i < 3; i++) begin
            frame(6, off, nstb, m);
            cmp("held_move", 32'(m), 32'(MOVE_LEFT));
            cmp("held_single_sample", 32'(nstb), 32'd1);
        end
        cmp("held_press_count", 32'(npress_l - n0), 32'd1);

        // conflict, then right drops; right was still held when the next frame opened
        gpio_right = 1'b1;
        repeat (8) step();
        frame(4, off, nstb, m);
        cmp("conflict_move", 32'(m), 32'(MOVE_NONE));
        gpio_right = 1'b0;
        repeat (10) step();
        frame(4, off, nstb, m);
        cmp("conflict_carry", 32'(m), 32'(MOVE_NONE));
        frame(4, off, nstb, m);
        cmp("conflict_resolved", 32'(m), 32'(MOVE_LEFT));
        gpio_left = 1'b0;
        repeat (10) step();
        frame(4, off, nstb, m);
        frame(4, off, nstb, m);
        cmp("idle_before_coincide", 32'(m), 32'(MOVE_NONE));

        // press lands exactly on the sample cycle
        gpio_left = 1'b1;
        repeat (5) step();
        v_tick = 1'b1;
        step();
        cmp("coincide_press", 32'(left_press), 32'd1);
        step();
        cmp("coincide_strobe", 32'(frame_strobe), 32'd1);
        cmp("coincide_move", 32'(move), 32'(MOVE_LEFT));
        v_tick = 1'b0;
        gpio_left = 1'b0;
        repeat (10) step();
        frame(4, off, nstb, m);
        frame(4, off, nstb, m);

        // reset while qualifying a rise restarts the full latency
        gpio_left = 1'b1;
        repeat (3) step();
        cmp("qual_level_low", 32'(left_lvl), 32'd0);
        async_reset(2);
        off = -1;
        for (int t = 1; t <= 10; t++) begin
            step();
            if (left_press && off < 0) off = t;
        end
        cmp("reset_requalify_offset", 32'(off), 32'd6);
        gpio_left = 1'b0;
        repeat (10) step();

        // randomized run against the model
        hl = 0; hr = 0; vcnt = 0; vper = 30; vhi = 3;
        for (int i = 0; i < 1500; i++) begin
            if (hl == 0) begin
                gpio_left = 1'($urandom_range(0, 1));
                hl = $urandom_range(1, 14);
            end else hl--;
            if (hr == 0) begin
                gpio_right = 1'($urandom_range(0, 1));
                hr = $urandom_range(1, 14);
            end else hr--;
            vcnt++;
            if (vcnt >= vper) begin
                vcnt = 0;
                vper = $urandom_range(15, 50);
                vhi  = $urandom_range(1, 8);
            end
            v_tick = (vcnt < vhi);
            if (i == 700) async_reset(2);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
